// File: rtl/spi_prog_loader_pkg.sv
// Shared encodings for the processor-loader link: pin codes, frame geometry,
// host command kinds and the loader state set.
// Latency: n/a (types and constants only). Backpressure: n/a.
package spi_prog_loader_pkg;

  // Values driven onto uio_in[1:0]
  localparam logic [1:0] SEL_IDLE = 2'b00;
  localparam logic [1:0] SEL_CSI  = 2'b01;
  localparam logic [1:0] SEL_CSD  = 2'b10;
  localparam logic [1:0] SEL_RUN  = 2'b11;

  localparam int FRAME_W = 12;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;
  localparam int BIT_W   = $clog2(FRAME_W);

  typedef enum logic [1:0] {
    CMD_INSTR = 2'b00,
    CMD_DATA  = 2'b01,
    CMD_RUN   = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_RUN_START,
    ST_RUN_WAIT
  } ld_state_e;

  // Chip-select code for a cache write command
  function automatic logic [1:0] cs_code(input cmd_kind_e kind);
    return (kind == CMD_DATA) ? SEL_CSD : SEL_CSI;
  endfunction

endpackage

// File: rtl/spi_prog_loader_if.sv
// Host command port of the loader: one command per valid&ready transfer.
// Latency: n/a (wiring only). Backpressure: ready from the loader, valid held by host.
// Signals: cmd_valid/cmd_ready handshake, cmd_kind, cmd_addr, cmd_data.
interface spi_prog_loader_if;
  import spi_prog_loader_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  cmd_kind_e             cmd_kind;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_data;

  modport master (
    output cmd_valid, cmd_kind, cmd_addr, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_addr, cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/spi_prog_loader_frame_serializer.sv
// Shifts one 12-bit frame out LSB first with a registered chip-select code.
// Latency: sel/mosi valid the cycle after start_i, frame occupies exactly 12 cycles.
// Backpressure: start_i is only honoured while busy_o is low; last_o flags the final bit.
// Ports: clk, rst, start_i, cs_i, frame_i, busy_o, last_o, sel_o, mosi_o.
module spi_prog_loader_frame_serializer
  import spi_prog_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         cs_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic               busy_o,
  output logic               last_o,
  output logic [1:0]         sel_o,
  output logic               mosi_o
);

  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
  logic               active_q, active_d;
  logic [1:0]         sel_q, sel_d;
  logic               mosi_q, mosi_d;

  assign last_o = active_q && (bitcnt_q == BIT_W'(FRAME_W - 1));
  assign busy_o = active_q;
  assign sel_o  = sel_q;
  assign mosi_o = mosi_q;

  always_comb begin
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    active_d = active_q;
    sel_d    = sel_q;
    mosi_d   = mosi_q;
    if (start_i && !active_q) begin
      // bit 0 goes straight to the pin register; the rest waits in shift_q
      shift_d  = frame_i >> 1;
      bitcnt_d = '0;
      active_d = 1'b1;
      sel_d    = cs_i;
      mosi_d   = frame_i[0];
    end else if (active_q) begin
      if (last_o) begin
        active_d = 1'b0;
        sel_d    = SEL_IDLE;
        mosi_d   = 1'b0;
      end else begin
        bitcnt_d = bitcnt_q + BIT_W'(1);
        mosi_d   = shift_q[0];
        shift_d  = shift_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      bitcnt_q <= '0;
      active_q <= 1'b0;
      sel_q    <= SEL_IDLE;
      mosi_q   <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      active_q <= active_d;
      sel_q    <= sel_d;
      mosi_q   <= mosi_d;
    end
  end

endmodule

// File: rtl/spi_prog_loader.sv
// Host-side master for the processor's 4-wire slave port: cache-word writes and timed runs.
// Latency: write = 1 accept + 12 shift + GAP_CYCLES; run = until proc_done or RUN_TIMEOUT, + GAP_CYCLES.
// Backpressure: cmd_ready is high only in IDLE, one command in flight at a time.
// Ports: clk, rst, cmd (valid/ready host port), sel_o/mosi_o/proc_done_i (processor pins),
//        run_cycles_o, run_done_o, run_timeout_o, cmd_err_o, busy_o (status).
module spi_prog_loader
  import spi_prog_loader_pkg::*;
#(
  parameter int               GAP_CYCLES  = 2,
  parameter int               CNT_W       = 16,
  parameter logic [CNT_W-1:0] RUN_TIMEOUT = CNT_W'(16'hFFFF)
) (
  input  logic              clk,
  input  logic              rst,
  spi_prog_loader_if.slave  cmd,
  output logic [1:0]        sel_o,
  output logic              mosi_o,
  input  logic              proc_done_i,
  output logic [CNT_W-1:0]  run_cycles_o,
  output logic              run_done_o,
  output logic              run_timeout_o,
  output logic              cmd_err_o,
  output logic              busy_o
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  ld_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   run_cycles_q, run_cycles_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               run_done_q, run_done_d;
  logic               run_to_q, run_to_d;
  logic               cmd_err_q, cmd_err_d;

  logic               ser_start;
  logic               ser_busy;
  logic               ser_last;
  logic [1:0]         ser_sel;
  logic               ser_mosi;
  logic               timeout_hit;
  logic [CNT_W-1:0]   cnt_inc;

  spi_prog_loader_frame_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .start_i (ser_start),
    .cs_i    (cs_code(cmd.cmd_kind)),
    .frame_i ({cmd.cmd_data, cmd.cmd_addr}),
    .busy_o  (ser_busy),
    .last_o  (ser_last),
    .sel_o   (ser_sel),
    .mosi_o  (ser_mosi)
  );

  assign cmd.cmd_ready = (state_q == ST_IDLE) && !ser_busy;
  assign busy_o        = (state_q != ST_IDLE);
  assign timeout_hit   = (cnt_q == RUN_TIMEOUT);
  assign cnt_inc       = timeout_hit ? cnt_q : cnt_q + CNT_W'(1);

  // Run enable drops in the same cycle done rises (or the limit is hit), so
  // the processor never sees enable together with idle and cannot restart.
  always_comb begin
    sel_o = SEL_IDLE;
    case (state_q)
      ST_SHIFT:     sel_o = ser_sel;
      ST_RUN_START: sel_o = timeout_hit ? SEL_IDLE : SEL_RUN;
      ST_RUN_WAIT:  sel_o = (proc_done_i || timeout_hit) ? SEL_IDLE : SEL_RUN;
      default:      sel_o = SEL_IDLE;
    endcase
  end

  assign mosi_o = ser_mosi;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gap_d        = '0;
    run_cycles_d = run_cycles_q;
    run_done_d   = 1'b0;
    run_to_d     = 1'b0;
    cmd_err_d    = 1'b0;
    ser_start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid && cmd.cmd_ready) begin
          case (cmd.cmd_kind)
            CMD_INSTR, CMD_DATA: begin
              ser_start = 1'b1;
              state_d   = ST_SHIFT;
            end
            CMD_RUN: begin
              cnt_d   = '0;
              state_d = ST_RUN_START;
            end
            default: cmd_err_d = 1'b1;
          endcase
        end
      end
      ST_SHIFT: begin
        if (ser_last) state_d = ST_GAP;
      end
      ST_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_RUN_START: begin
        // proc_done still high here means the processor has not left idle yet
        if (timeout_hit) begin
          run_cycles_d = RUN_TIMEOUT;
          run_to_d     = 1'b1;
          state_d      = ST_GAP;
        end else begin
          cnt_d = cnt_inc;
          if (!proc_done_i) state_d = ST_RUN_WAIT;
        end
      end
      ST_RUN_WAIT: begin
        // done takes priority when it coincides with the limit
        if (proc_done_i) begin
          run_cycles_d = cnt_q;
          run_done_d   = 1'b1;
          state_d      = ST_GAP;
        end else if (timeout_hit) begin
          run_cycles_d = RUN_TIMEOUT;
          run_to_d     = 1'b1;
          state_d      = ST_GAP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      run_cycles_q <= '0;
      gap_q        <= '0;
      run_done_q   <= 1'b0;
      run_to_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_cycles_q <= run_cycles_d;
      gap_q        <= gap_d;
      run_done_q   <= run_done_d;
      run_to_q     <= run_to_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign run_cycles_o  = run_cycles_q;
  assign run_done_o    = run_done_q;
  assign run_timeout_o = run_to_q;
  assign cmd_err_o     = cmd_err_q;

endmodule

// File: tb/tb_spi_prog_loader.sv
// Scoreboarded bench: host driver pushes expected events, a negedge monitor pops and compares.
// A behavioural processor slave captures frames into cache arrays and runs for a chosen length.
module tb_spi_prog_loader;
  import spi_prog_loader_pkg::*;

  localparam int          GAP = 2;
  localparam logic [15:0] TO  = 16'd8;

  localparam int EV_I    = 0;
  localparam int EV_D    = 1;
  localparam int EV_DONE = 2;
  localparam int EV_TO   = 3;
  localparam int EV_ERR  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_prog_loader_if ifc();

  logic [1:0]  sel;
  logic        mosi;
  logic        proc_done;
  logic [15:0] run_cycles;
  logic        run_done, run_timeout, cmd_err, busy;

  spi_prog_loader #(.GAP_CYCLES(GAP), .CNT_W(16), .RUN_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (ifc.slave),
    .sel_o        (sel),
    .mosi_o       (mosi),
    .proc_done_i  (proc_done),
    .run_cycles_o (run_cycles),
    .run_done_o   (run_done),
    .run_timeout_o(run_timeout),
    .cmd_err_o    (cmd_err),
    .busy_o       (busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    logic [11:0] frame;
    logic [15:0] cyc;
  } ev_t;
  ev_t expq[$];

  // ---------------- behavioural processor slave ----------------
  logic [7:0]  icache [16];
  logic [7:0]  dcache [16];
  logic [11:0] p_sh;
  int          p_n;
  logic [1:0]  p_cs;
  logic        p_exec;
  int          p_cnt;
  int          p_entries = 0;
  int          p_len = 1;
  logic        hang = 1'b0;

  assign proc_done = hang ? 1'b0 : !p_exec;

  always @(posedge clk) begin
    if (rst) begin
      p_sh   <= '0;
      p_n    <= 0;
      p_cs   <= SEL_IDLE;
      p_exec <= 1'b0;
      p_cnt  <= 0;
    end else begin
      if (sel == SEL_CSI || sel == SEL_CSD) begin
        p_sh <= {mosi, p_sh[11:1]};
        p_n  <= p_n + 1;
        p_cs <= sel;
      end else if (p_n != 0) begin
        if (p_n == 12) begin
          if (p_cs == SEL_CSI) icache[p_sh[3:0]] <= p_sh[11:4];
          else                 dcache[p_sh[3:0]] <= p_sh[11:4];
        end
        p_n <= 0;
      end
      if (p_exec) begin
        if (p_cnt <= 1) p_exec <= 1'b0;
        else            p_cnt  <= p_cnt - 1;
      end else if (sel == SEL_RUN && !hang) begin
        p_exec    <= 1'b1;
        p_cnt     <= p_len;
        p_entries <= p_entries + 1;
      end
    end
  end

  // ---------------- reference state ----------------
  logic [7:0] ref_i [16];
  logic [7:0] ref_d [16];
  bit         ref_iv [16];
  bit         ref_dv [16];
  int         entry_base = 0;

  task automatic fail_line(input string name, input logic [31:0] got, input logic [31:0] want);
    errors++;
    $display("FAIL %s got=%0h want=%0h", name, got, want);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) fail_line(name, got, want);
  endtask

  // ---------------- monitor ----------------
  task automatic match_ev(input int kind, input logic [11:0] fr, input logic [15:0] cyc);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      fail_line("unexpected_event", 32'(kind), 32'hFFFF);
      return;
    end
    e = expq.pop_front();
    if (e.kind != kind) fail_line("event_kind", 32'(kind), 32'(e.kind));
    else if ((kind == EV_I || kind == EV_D) && fr !== e.frame) fail_line("frame_bits", 32'(fr), 32'(e.frame));
    else if ((kind == EV_DONE || kind == EV_TO) && cyc !== e.cyc) fail_line("run_cycles", 32'(cyc), 32'(e.cyc));
  endtask

  logic [11:0] m_fr;
  int          m_n = 0;
  logic [1:0]  m_sel = SEL_IDLE;
  int          m_s11 = 0;
  logic        m_pd = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_n   = 0;
        m_s11 = 0;
      end else begin
        if (sel == SEL_CSI || sel == SEL_CSD) begin
          if (m_n < 12) m_fr[m_n] = mosi;
          m_n++;
          m_sel = sel;
        end else begin
          if (mosi !== 1'b0) begin
            checks++;
            fail_line("mosi_outside_shift", 32'(mosi), 0);
          end
          if (m_n != 0) begin
            chk("frame_len", 32'(m_n), 32'd12);
            match_ev((m_sel == SEL_CSI) ? EV_I : EV_D, m_fr, '0);
            m_n = 0;
          end
        end
        if (sel == SEL_RUN) m_s11++;
        // enable must already be low in the cycle done rises during a run
        if (busy && proc_done && !m_pd && !hang) chk("sel_on_done_rise", 32'(sel), 32'(SEL_IDLE));
        if (run_done) begin
          match_ev(EV_DONE, '0, run_cycles);
          chk("cycles_vs_enable", 32'(run_cycles), 32'(m_s11));
          chk("exec_entries", 32'(p_entries - entry_base), 32'd1);
          m_s11 = 0;
        end
        if (run_timeout) begin
          match_ev(EV_TO, '0, run_cycles);
          chk("to_cycles_vs_enable", 32'(run_cycles), 32'(m_s11));
          m_s11 = 0;
        end
        if (cmd_err) match_ev(EV_ERR, '0, '0);
      end
      m_pd = proc_done;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [1:0] k, input logic [3:0] a, input logic [7:0] d, input bit exp_on);
    int  g = 0;
    ev_t e;
    @(negedge clk);
    while (!ifc.cmd_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      checks++;
      fail_line("accept_timeout", 32'(g), 0);
    end
    e.frame = {d, a};
    e.cyc   = '0;
    case (k)
      2'd0: begin e.kind = EV_I; if (exp_on) begin ref_i[a] = d; ref_iv[a] = 1'b1; end end
      2'd1: begin e.kind = EV_D; if (exp_on) begin ref_d[a] = d; ref_dv[a] = 1'b1; end end
      2'd2: begin
        entry_base = p_entries;
        // enable is up one cycle before the processor leaves idle, then p_len exec cycles
        if (!hang && (p_len + 1) <= int'(TO)) begin e.kind = EV_DONE; e.cyc = 16'(p_len + 1); end
        else begin e.kind = EV_TO; e.cyc = TO; end
      end
      default: e.kind = EV_ERR;
    endcase
    if (exp_on) expq.push_back(e);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_kind  = cmd_kind_e'(k);
    ifc.cmd_addr  = a;
    ifc.cmd_data  = d;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ifc.cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int r;

  initial begin
    ifc.cmd_valid = 1'b0;
    ifc.cmd_kind  = CMD_INSTR;
    ifc.cmd_addr  = '0;
    ifc.cmd_data  = '0;
    for (int i = 0; i < 16; i++) begin ref_iv[i] = 1'b0; ref_dv[i] = 1'b0; end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_ready", 32'(ifc.cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_run_cycles", 32'(run_cycles), 0);
    chk("rst_pulses", {29'd0, run_done, run_timeout, cmd_err}, 0);
    #2 rst = 1'b0;

    // instruction word, with turnaround timing
    send(2'd0, 4'h3, 8'hA5, 1'b1);
    wait_ready(n);
    chk("write_turnaround", 32'(n), 32'(12 + GAP));
    chk("icache3", 32'(icache[3]), 32'hA5);

    // data word
    send(2'd1, 4'hF, 8'h80, 1'b1);
    wait_ready(n);
    chk("dcache15", 32'(dcache[15]), 32'h80);
    chk("icache3_kept", 32'(icache[3]), 32'hA5);

    // normal run, then the done/limit coincidence
    send(2'd0, 4'h0, 8'h11, 1'b1);
    send(2'd0, 4'h1, 8'h22, 1'b1);
    p_len = 3;
    send(2'd2, 4'h0, 8'h00, 1'b1);
    wait_ready(n);
    p_len = 7;
    send(2'd2, 4'h0, 8'h00, 1'b1);
    wait_ready(n);

    // hung processor: limit reached
    hang = 1'b1;
    send(2'd2, 4'h0, 8'h00, 1'b1);
    wait_ready(n);
    chk("timeout_turnaround", 32'(n), 32'(9 + GAP));
    chk("timeout_busy", 32'(busy), 0);
    hang = 1'b0;

    // reserved command
    send(2'd3, 4'h7, 8'h55, 1'b1);
    chk("rsvd_ready", 32'(ifc.cmd_ready), 1);
    chk("rsvd_sel", 32'(sel), 0);

    // reset on bit 6 of a frame, then a clean rewrite of the same address
    send(2'd0, 4'h5, 8'hFF, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sel", 32'(sel), 0);
    chk("midrst_mosi", 32'(mosi), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_run_cycles", 32'(run_cycles), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    send(2'd0, 4'h5, 8'h3C, 1'b1);
    wait_ready(n);
    chk("icache5_after_rst", 32'(icache[5]), 32'h3C);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) send(2'd0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b1);
      else if (r <= 6) send(2'd1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b1);
      else if (r <= 8) begin
        wait_ready(n);
        p_len = int'($urandom_range(1, 9));
        hang  = ($urandom_range(0, 5) == 0);
        send(2'd2, 4'h0, 8'h00, 1'b1);
        wait_ready(n);
        hang = 1'b0;
      end else send(2'd3, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b1);
    end

    wait_ready(n);
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("events_outstanding", 32'(expq.size()), 0);
    for (int i = 0; i < 16; i++) begin
      if (ref_iv[i]) chk("icache_final", {20'd0, 4'(i), icache[i]}, {20'd0, 4'(i), ref_i[i]});
      if (ref_dv[i]) chk("dcache_final", {20'd0, 4'(i), dcache[i]}, {20'd0, 4'(i), ref_d[i]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=1 want=0");
    $fatal(1);
  end

endmodule

// File: doc/spi_prog_loader.md
Name: spi_prog_loader

Overview:
- Off-chip-side master that feeds the tiny processor over its 4-wire slave interface.
- The pins are en/cs encoding `sel[1:0]`, `mosi`, and `proc_done`.
- It accepts host commands through a valid/ready port, one command at a time:
  - write one instruction-cache word;
  - write one data-cache word;
  - run the program.
- It serialises 12-bit frames, drives the run-enable, and measures run length.
- It sits between the FPGA-demo/testbench host logic and the processor's `uio_in[2:0]` / `uio_out[3]` pins.

Parameters:
- `GAP_CYCLES`, default 2: idle (`sel=00`) cycles after every frame and after every run; minimum 1.
- `CNT_W`, default 16: width of the run cycle counter.
- `RUN_TIMEOUT`, default 16'hFFFF: run aborts when the counter reaches this value.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `cmd_valid`, input, 1: host command present.
- `cmd_ready`, output, 1: loader can accept a command.
- `cmd_kind`, input, 2: 00 = instr write, 01 = data write, 10 = run, 11 = reserved.
- `cmd_addr`, input, 4: cache address.
- `cmd_data`, input, 8: cache word.
- `sel`, output, 2: to `uio_in[1:0]`. 00 idle, 01 csi, 10 csd, 11 run-enable.
- `mosi`, output, 1: to `uio_in[2]`.
- `proc_done`, input, 1: from `uio_out[3]`. High while the processor is idle.
- `run_cycles`, output, `CNT_W`: cycles spent in the last run.
- `run_done`, output, 1: one-cycle pulse when a run ends normally.
- `run_timeout`, output, 1: one-cycle pulse when a run is aborted.
- `cmd_err`, output, 1: one-cycle pulse when a reserved command is accepted.
- `busy`, output, 1: high whenever state ≠ IDLE.

Behaviour:
- Reset (async, immediate) sets:
  - state = IDLE;
  - `sel` = 00, `mosi` = 0;
  - `cmd_ready` = 1 (combinational with IDLE);
  - `run_cycles` = 0;
  - all pulses = 0.
- Reset mid-frame or mid-run abandons the operation; the processor discards the partial frame and leaves EXEC on the next edge.
- States: IDLE, SHIFT, GAP, RUN_START, RUN_WAIT.
- A command is accepted when `cmd_valid & cmd_ready`. `cmd_ready` is high only in IDLE.
- IDLE, instr/data write accepted:
  - latch frame = `{cmd_data, cmd_addr}` (12 bits);
  - latch cs code (01 or 10);
  - clear bit counter;
  - next state SHIFT.
- SHIFT:
  - registered `sel` = cs code; `mosi` = frame[bitcnt], LSB first, so `addr[0]` is sent first and `data[7]` last;
  - exactly 12 cycles, then GAP;
  - after 12 shifts the slave register holds `data` in [11:4] and `addr` in [3:0].
- GAP:
  - `sel` = 00, `mosi` = 0 for `GAP_CYCLES` cycles, then IDLE;
  - the slave commits the cache write in the first GAP cycle.
  - Back-to-back commands therefore cost 12 + `GAP_CYCLES` cycles per word plus 1 IDLE accept cycle.
- IDLE, run accepted:
  - `sel` = 11, clear counter, next state RUN_START.
- RUN_START:
  - wait for `proc_done` = 0, then RUN_WAIT;
  - counter increments every cycle from the first `sel=11` cycle.
- RUN_WAIT:
  - counter increments, saturating at `RUN_TIMEOUT`;
  - `sel` is driven combinationally as `proc_done ? 00 : 11`. This forces the enable low in the same cycle `done` rises, so the processor never re-enters EXEC and never re-executes instruction 0.
  - On `proc_done` = 1: latch `run_cycles`, pulse `run_done`, go to GAP.
- Timeout:
  - if the counter reaches `RUN_TIMEOUT` in RUN_START or RUN_WAIT, drive `sel` = 00;
  - latch `run_cycles` = `RUN_TIMEOUT`, pulse `run_timeout`, go to GAP.
  - If done and timeout occur in the same cycle, done wins.
- Reserved command (`cmd_kind` = 11): accepted, `cmd_err` pulses, state stays IDLE, `sel` unchanged.
- `mosi` is 0 outside SHIFT.
- `sel` is never 01 or 10 outside SHIFT, and never 11 outside a run.

Decomposition:
- Shared package `proc_if_pkg`:
  - `sel` encodings `SEL_IDLE` = 2'b00, `SEL_CSI` = 2'b01, `SEL_CSD` = 2'b10, `SEL_RUN` = 2'b11;
  - `FRAME_W` = 12, `ADDR_W` = 4, `DATA_W` = 8;
  - `cmd_kind` encodings;
  - loader state enum.
- One sub-module is natural: `frame_serializer`. It holds the 12-bit shift, the bit counter, and `sel`/`mosi` registering, with `start`/`busy` handshake.
- The FSM, counter and pulses stay in the top.

Test Plan:
- Instr write: kind=00, addr=4'h3, data=8'hA5.
  - `sel`=01 for exactly 12 cycles.
  - mosi sequence = 1,1,0,0,1,0,1,0,0,1,0,1.
  - Then `sel`=00 for 2 cycles and `cmd_ready` returns; the processor icache[3] reads 8'hA5.
- Data write: kind=01, addr=4'hF, data=8'h80.
  - `sel`=10 for 12 cycles; dcache[15] = 8'h80; icache unchanged.
- Run: load a 2-instruction program ending at pc=15.
  - `sel`=11 until the cycle `proc_done` rises, then 00 in that same cycle.
  - `run_done` pulses once; `run_cycles` equals the measured count.
  - The processor does not re-enter EXEC.
- Timeout: set `RUN_TIMEOUT`=8 and tie `proc_done`=0.
  - After 8 cycles `sel`=00, `run_timeout` pulses, `run_cycles`=8, `busy` falls after GAP.
- Reserved: kind=11 → `cmd_err` pulse, `sel` stays 00, `cmd_ready` stays 1.
- Reset on bit 6 of a frame: assert `rst`.
  - `sel`=00 and `mosi`=0 immediately.
  - A subsequent full write to the same address succeeds with correct data.
